// File: rtl/fifo_stat.sv
// fifo_stat: synchronous show-ahead FIFO with registered level flags and sticky overflow/underflow.
module fifo_stat #(
  parameter int ADR_WIDTH = 8,
  parameter int DAT_WIDTH = 8,
  parameter int AF_LEVEL = (1 << ADR_WIDTH) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 rd,
  input  logic                 clr_err,
  input  logic [DAT_WIDTH-1:0] data_in,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int DEPTH = 1 << ADR_WIDTH;
  localparam logic [ADR_WIDTH:0] DEP = (ADR_WIDTH+1)'(DEPTH);
  localparam logic [ADR_WIDTH:0] AF = (ADR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADR_WIDTH:0] AE = (ADR_WIDTH+1)'(AE_LEVEL);
  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [ADR_WIDTH-1:0] w_ptr, r_ptr;
  logic [ADR_WIDTH:0]   count_nxt;
  logic                 rd_acc, wr_acc;
  assign rd_acc = rd && !empty;
  assign wr_acc = wr && (!full || rd_acc);
  assign data_out = mem[r_ptr];
  // Flags are registered from the next count so they line up with count itself.
  always_comb
    count_nxt = reset ? '0 :
                (wr_acc && !rd_acc) ? count + 1'b1 :
                (rd_acc && !wr_acc) ? count - 1'b1 : count;
  always_ff @(posedge clk) begin
    count        <= count_nxt;
    empty        <= count_nxt == '0;
    full         <= count_nxt == DEP;
    almost_empty <= count_nxt <= AE;
    almost_full  <= count_nxt >= AF;
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      overflow  <= (overflow && !clr_err) || (wr && full && !rd_acc);
      underflow <= (underflow && !clr_err) || (rd && empty);
    end
  end
  always_ff @(posedge clk)
    if (wr_acc && !reset) mem[w_ptr] <= data_in;
endmodule

// File: tb/tb_fifo_stat.sv
// tb_fifo_stat: directed and random stimulus against a queue-based FIFO model.
module tb_fifo_stat;
  logic       clk = 1'b0;
  logic       reset, wr, rd, clr_err;
  logic [7:0] data_in, data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit m_ov, m_un;

  fifo_stat #(.ADR_WIDTH(2), .DAT_WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .clr_err(clr_err),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit w, input bit r, input bit c, input bit rst, input logic [7:0] d);
    bit e, f, racc, wacc;
    int n;
    wr = w; rd = r; clr_err = c; reset = rst; data_in = d;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_ov = 0; m_un = 0;
    end else begin
      e = q.size() == 0;
      f = q.size() == 4;
      racc = r && !e;
      wacc = w && (!f || racc);
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
      m_ov = (m_ov && !c) || (w && f && !racc);
      m_un = (m_un && !c) || (r && e);
    end
    #1;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 4));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
    chk("almost_full", 32'(almost_full), 32'(n >= 3));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
    if (n != 0) chk("data_out", 32'(data_out), 32'(q[0]));
  endtask

  initial begin
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1; wr = 0; rd = 0; clr_err = 0; data_in = 0;
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 8'hEE);
    chk("reset_blocks_write", 32'(count), 32'd0);
    foreach (vals[i]) step(1, 0, 0, 0, vals[i]);
    chk("fill_head", 32'(data_out), 32'h11);
    step(1, 0, 0, 0, 8'h55);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("unf_set", 32'(underflow), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("err_clear", 32'(underflow | overflow), 32'd0);
    step(0, 1, 1, 0, 0);
    chk("err_new_wins", 32'(underflow), 32'd1);
    step(0, 0, 1, 0, 0);
    foreach (vals[i]) step(1, 0, 0, 0, vals[i]);
    step(1, 1, 0, 0, 8'hA5);
    chk("full_rw_count", 32'(count), 32'd4);
    chk("full_rw_head", 32'(data_out), 32'h22);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("last_word", 32'(data_out), 32'hA5);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 8'h5A);
    chk("empty_rw_head", 32'(data_out), 32'h5A);
    chk("empty_rw_unf", 32'(underflow), 32'd1);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 8'(8'h30 + i));
      step(0, 1, 0, 0, 0);
    end
    step(1, 0, 0, 0, 8'h77);
    step(1, 0, 0, 0, 8'h78);
    step(0, 0, 0, 1, 0);
    chk("mid_reset_empty", 32'(empty), 32'd1);
    step(1, 0, 0, 0, 8'h99);
    chk("post_reset_head", 32'(data_out), 32'h99);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2, 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_stat.md
FIFO_STAT -- requirements
Module: fifo_stat

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 8: address width; depth DEPTH = 2^ADR_WIDTH words.
REQ-002 SHALL have parameter DAT_WIDTH, default 8: data word width.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr  input  1  write request.
REQ-008 SHALL have port rd  input  1  read request; pops the current head word.
REQ-009 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-010 SHALL have port data_in  input  DAT_WIDTH  write data.
REQ-011 SHALL have port data_out  output  DAT_WIDTH  head word, show-ahead.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-015 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-016 SHALL have port count  output  ADR_WIDTH+1  words stored, range 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky: write attempted while full without an accepted read.
REQ-018 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 SHALL accept a write (wr_acc) when wr=1 and (full=0 or rd_acc=1); data_in stored at w_ptr, w_ptr increments mod DEPTH.
REQ-020 SHALL accept a read (rd_acc) when rd=1 and empty=0; r_ptr increments mod DEPTH.
REQ-021 SHALL, on rd=1 and wr=1 with empty=1: write only, count +1, underflow set.
REQ-022 SHALL, on rd=1 and wr=1 with full=1: both accepted, count unchanged, overflow not set.
REQ-023 SHALL update count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-024 SHALL register empty, full, almost_empty and almost_full from the next count value, so all flags are valid in the cycle after the causing edge with zero extra latency.
REQ-025 SHALL drive data_out combinationally from mem[r_ptr]; the first write into an empty FIFO is visible on data_out one cycle after its edge.
REQ-026 SHALL leave data_out undefined while empty=1; the bench SHALL NOT check it then.
REQ-027 SHALL set overflow on any edge with wr=1, full=1, rd_acc=0; the write is dropped, and pointers and memory are unchanged.
REQ-028 SHALL set underflow on any edge with rd=1 and empty=1; r_ptr is unchanged.
REQ-029 SHALL clear overflow and underflow on clr_err=1; a new error in the same cycle wins (flag stays set).
REQ-030 SHALL wrap pointers from DEPTH-1 to 0 with no gap or duplicate word.
REQ-031 SHALL hold memory contents with no write enable asserted; memory is not reset.

Reset
REQ-032 SHALL, on clk edge with reset=1: w_ptr=0, r_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (1 only if AF_LEVEL==0), overflow=0, underflow=0.
REQ-033 SHALL give reset priority over wr, rd and clr_err in the same cycle; no write is accepted.
REQ-034 SHALL, on reset mid-operation, discard all stored words; the first post-reset write appears on data_out one cycle later.

Verification (ADR_WIDTH=2, DAT_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 SHALL cover: reset, then write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops after count=2; almost_full at 3; full at 4; data_out=0x11.
REQ-036 SHALL cover: full, then wr=1 with data 0x55 -> overflow=1, count=4; four reads return 0x11,0x22,0x33,0x44; empty=1.
REQ-037 SHALL cover: empty, then rd=1 -> underflow=1, count=0; then clr_err=1 -> underflow=0.
REQ-038 SHALL cover: full, then rd=wr=1 with 0xA5 -> count stays 4, overflow=0, head advances; after 4 reads the last word is 0xA5.
REQ-039 SHALL cover: empty, then rd=wr=1 with 0x5A -> count=1, underflow=1, data_out=0x5A.
REQ-040 SHALL cover: 10 write/read pairs crossing pointer wrap -> data order preserved; then reset with count=2 -> empty=1, count=0 next cycle.
